// File: rtl/vcpu32_pkg.sv
// rtl/vcpu32_pkg.sv - shared widths and the write-back queue entry type
package vcpu32_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_COUNT      = 8;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order queue of write-back entries, all slots visible for lookup
module wb_fifo
    import vcpu32_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  wb_entry_t       push_entry_i,
    input  logic            pop_i,
    output wb_entry_t       head_entry_o,
    output logic            full_o,
    output logic [LW-1:0]   level_o,
    output logic [PW-1:0]   head_o,
    output wb_entry_t       entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [LW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o = (count_q == LW'(DEPTH));

    // Push into the slot a same-cycle pop frees is refused: full blocks push outright.
    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop_ok) begin
            head_d          = ptr_inc(head_q);
            valid_d[head_q] = 1'b0;
        end
        if (push_ok) begin
            tail_d          = ptr_inc(tail_q);
            valid_d[tail_q] = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign level_o      = count_q;
    assign head_o       = head_q;
    assign entries_o    = mem_q;
    assign valid_o      = valid_q;

endmodule

// File: rtl/reg_write_back_unit.sv
// rtl/reg_write_back_unit.sv - write-back arbiter/queue feeding the regfile port; forwarding via VCPU32_WB_FWD_EN
module reg_write_back_unit
    import vcpu32_pkg::*;
#(
    parameter  int WIDTH = WORD_WIDTH,
    parameter  int SIZE  = REG_COUNT,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(SIZE),
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memValid,
    input  logic [AW-1:0]    memAddr,
    input  logic [WIDTH-1:0] memData,
    output logic             memReady,
    input  logic             aluValid,
    input  logic [AW-1:0]    aluAddr,
    input  logic [WIDTH-1:0] aluData,
    output logic             aluReady,
    input  logic             wbHold,
    output logic             write,
    output logic [AW-1:0]    wrAddr,
    output logic [WIDTH-1:0] wrData,
    output logic [LW-1:0]    level,
    output logic             pending,
    input  logic [AW-1:0]    fwdAddrA,
    input  logic [AW-1:0]    fwdAddrB,
    output logic             fwdHitA,
    output logic [WIDTH-1:0] fwdDataA,
    output logic             fwdHitB,
    output logic [WIDTH-1:0] fwdDataB
);

    logic             fifo_full;
    logic [LW-1:0]    fifo_level;
    logic [PW-1:0]    fifo_head;
    wb_entry_t        fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    wb_entry_t        head_entry;
    wb_entry_t        push_entry;
    logic             push;
    logic             pop;

    logic             write_q, write_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    // Readies look only at occupancy and memValid, never at their own valid.
    assign memReady = !rst && !fifo_full;
    assign aluReady = !rst && !fifo_full && !memValid;

    assign push = (memValid && memReady) || (aluValid && aluReady);
    assign pop  = !wbHold && (fifo_level != '0);

    always_comb begin
        push_entry = '0;
        if (memValid) begin
            push_entry.addr = memAddr;
            push_entry.data = memData;
        end else begin
            push_entry.addr = aluAddr;
            push_entry.data = aluData;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .full_o       (fifo_full),
        .level_o      (fifo_level),
        .head_o       (fifo_head),
        .entries_o    (fifo_entries),
        .valid_o      (fifo_valid)
    );

    always_comb begin
        write_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            write_d   = 1'b1;
            wr_addr_d = head_entry.addr;
            wr_data_d = head_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            write_q   <= write_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign write   = write_q;
    assign wrAddr  = wr_addr_q;
    assign wrData  = wr_data_q;
    assign level   = fifo_level;
    assign pending = (fifo_level != '0) || write_q;

`ifdef VCPU32_WB_FWD_EN
    // Walk oldest to youngest so the youngest match overrides; output register is lowest priority.
    always_comb begin
        logic [PW-1:0] idx;
        int unsigned   s;
        fwdHitA  = 1'b0;
        fwdDataA = '0;
        fwdHitB  = 1'b0;
        fwdDataB = '0;
        idx      = '0;
        s        = 0;
        if (write_q && (wr_addr_q == fwdAddrA)) begin
            fwdHitA  = 1'b1;
            fwdDataA = wr_data_q;
        end
        if (write_q && (wr_addr_q == fwdAddrB)) begin
            fwdHitB  = 1'b1;
            fwdDataB = wr_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            s = int'(fifo_head) + k;
            if (s >= DEPTH) begin
                s = s - DEPTH;
            end
            idx = PW'(s);
            if (fifo_valid[idx] && (fifo_entries[idx].addr == fwdAddrA)) begin
                fwdHitA  = 1'b1;
                fwdDataA = fifo_entries[idx].data;
            end
            if (fifo_valid[idx] && (fifo_entries[idx].addr == fwdAddrB)) begin
                fwdHitB  = 1'b1;
                fwdDataB = fifo_entries[idx].data;
            end
        end
    end
`else
    localparam int EW = $bits(wb_entry_t);
    logic [DEPTH*EW-1:0] unused_flat;
    logic                unused_fwd;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign unused_flat[g*EW +: EW] = fifo_entries[g];
    end

    assign unused_fwd = ^{fwdAddrA, fwdAddrB, fifo_head, fifo_valid, unused_flat};
    assign fwdHitA    = 1'b0;
    assign fwdDataA   = '0;
    assign fwdHitB    = 1'b0;
    assign fwdDataB   = '0;
`endif

endmodule

// File: tb/tb_reg_write_back_unit.sv
// tb/tb_reg_write_back_unit.sv - randomized and directed checks of reg_write_back_unit against a queue model
module tb_reg_write_back_unit;

    localparam int AW    = 3;
    localparam int W     = 32;
    localparam int DEPTH = 4;
`ifdef VCPU32_WB_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          memValid, aluValid, wbHold;
    logic [AW-1:0] memAddr, aluAddr, fwdAddrA, fwdAddrB;
    logic [W-1:0]  memData, aluData;
    logic          memReady, aluReady, write, pending, fwdHitA, fwdHitB;
    logic [AW-1:0] wrAddr;
    logic [W-1:0]  wrData, fwdDataA, fwdDataB;
    logic [2:0]    level;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } ent_t;

    always #5 clk = ~clk;

    reg_write_back_unit dut (
        .clk(clk), .rst(rst),
        .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
        .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
        .wbHold(wbHold), .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .level(level), .pending(pending),
        .fwdAddrA(fwdAddrA), .fwdAddrB(fwdAddrB),
        .fwdHitA(fwdHitA), .fwdDataA(fwdDataA), .fwdHitB(fwdHitB), .fwdDataB(fwdDataB)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (memReady !== 1'b0) $display("FAIL rst_memready_in_reset got %b exp 0", memReady); else passed++;
        total++; if (aluReady !== 1'b0) $display("FAIL rst_aluready_in_reset got %b exp 0", aluReady); else passed++;
        rst = 1'b0;
        #1;
        total++; if (write !== 1'b0) $display("FAIL rst_write got %b exp 0", write); else passed++;
        total++; if (wrAddr !== 3'd0) $display("FAIL rst_wraddr got %0d exp 0", wrAddr); else passed++;
        total++; if (wrData !== 32'd0) $display("FAIL rst_wrdata got %h exp 0", wrData); else passed++;
        total++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else passed++;
        total++; if (memReady !== 1'b1) $display("FAIL rst_memready got %b exp 1", memReady); else passed++;
        total++; if (aluReady !== 1'b1) $display("FAIL rst_aluready got %b exp 1", aluReady); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL rst_pending got %b exp 0", pending); else passed++;
    endtask

    task automatic test_single_alu();
        aluValid = 1'b1; aluAddr = 3'd3; aluData = 32'hDEADBEEF;
        #1;
        total++; if (aluReady !== 1'b1) $display("FAIL single_ready got %b exp 1", aluReady); else passed++;
        tick();
        aluValid = 1'b0;
        total++; if (write !== 1'b0) $display("FAIL single_early_write got %b exp 0", write); else passed++;
        total++; if (level !== 3'd1) $display("FAIL single_level got %0d exp 1", level); else passed++;
        total++; if (pending !== 1'b1) $display("FAIL single_pending got %b exp 1", pending); else passed++;
        tick();
        total++; if (write !== 1'b1) $display("FAIL single_write got %b exp 1", write); else passed++;
        total++; if (wrAddr !== 3'd3) $display("FAIL single_addr got %0d exp 3", wrAddr); else passed++;
        total++; if (wrData !== 32'hDEADBEEF) $display("FAIL single_data got %h exp deadbeef", wrData); else passed++;
        tick();
        total++; if (write !== 1'b0) $display("FAIL single_pulse_len got %b exp 0", write); else passed++;
        total++; if (pending !== 1'b0) $display("FAIL single_idle_pending got %b exp 0", pending); else passed++;
    endtask

    task automatic test_arbitration();
        memValid = 1'b1; memAddr = 3'd5; memData = 32'h11111111;
        aluValid = 1'b1; aluAddr = 3'd6; aluData = 32'h22222222;
        #1;
        total++; if (aluReady !== 1'b0) $display("FAIL arb_aluready got %b exp 0", aluReady); else passed++;
        total++; if (memReady !== 1'b1) $display("FAIL arb_memready got %b exp 1", memReady); else passed++;
        tick();
        memValid = 1'b0;
        #1;
        total++; if (aluReady !== 1'b1) $display("FAIL arb_aluready2 got %b exp 1", aluReady); else passed++;
        tick();
        aluValid = 1'b0;
        total++; if (write !== 1'b1 || wrAddr !== 3'd5 || wrData !== 32'h11111111)
            $display("FAIL arb_first got %b/%0d/%h exp 1/5/11111111", write, wrAddr, wrData); else passed++;
        tick();
        total++; if (write !== 1'b1 || wrAddr !== 3'd6 || wrData !== 32'h22222222)
            $display("FAIL arb_second got %b/%0d/%h exp 1/6/22222222", write, wrAddr, wrData); else passed++;
        tick();
        total++; if (write !== 1'b0 || level !== 3'd0)
            $display("FAIL arb_drained got write %b level %0d exp 0/0", write, level); else passed++;
    endtask

    task automatic test_hold_full();
        logic [W-1:0]  ed [5];
        logic [AW-1:0] ea [5];
        for (int i = 0; i < 5; i++) begin
            ed[i] = $urandom;
            ea[i] = (i < 4) ? AW'(i + 1) : 3'd7;
        end
        wbHold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aluValid = 1'b1; aluAddr = ea[i]; aluData = ed[i];
            tick();
        end
        aluAddr = ea[4]; aluData = ed[4];
        #1;
        total++; if (level !== 3'd4) $display("FAIL full_level got %0d exp 4", level); else passed++;
        total++; if (memReady !== 1'b0) $display("FAIL full_memready got %b exp 0", memReady); else passed++;
        total++; if (aluReady !== 1'b0) $display("FAIL full_aluready got %b exp 0", aluReady); else passed++;
        total++; if (write !== 1'b0) $display("FAIL full_hold_write got %b exp 0", write); else passed++;
        tick();
        total++; if (level !== 3'd4) $display("FAIL full_fifth_waits got %0d exp 4", level); else passed++;
        wbHold = 1'b0;
        #1;
        total++; if (aluReady !== 1'b0) $display("FAIL full_no_slot_reuse got %b exp 0", aluReady); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (write !== 1'b1 || wrAddr !== ea[i] || wrData !== ed[i])
                $display("FAIL full_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, write, wrAddr, wrData, ea[i], ed[i]); else passed++;
            if (i == 0) begin
                total++; if (aluReady !== 1'b1) $display("FAIL full_reopen got %b exp 1", aluReady); else passed++;
            end
            if (i == 1) aluValid = 1'b0;
        end
        tick();
        total++; if (write !== 1'b0 || level !== 3'd0)
            $display("FAIL full_end got write %b level %0d exp 0/0", write, level); else passed++;
    endtask

    task automatic test_forwarding();
        logic          eh;
        logic [W-1:0]  e_b;
        wbHold = 1'b1;
        aluValid = 1'b1; aluAddr = 3'd2; aluData = 32'h0000000A;
        tick();
        aluData = 32'h0000000B;
        tick();
        aluValid = 1'b0;
        fwdAddrA = 3'd2; fwdAddrB = 3'd7;
        eh  = FWD_ON;
        e_b = FWD_ON ? 32'h0000000B : 32'h0;
        #1;
        total++; if (fwdHitA !== eh || fwdDataA !== e_b)
            $display("FAIL fwd_queue_young got %b/%h exp %b/%h", fwdHitA, fwdDataA, eh, e_b); else passed++;
        total++; if (fwdHitB !== 1'b0 || fwdDataB !== 32'h0)
            $display("FAIL fwd_miss got %b/%h exp 0/0", fwdHitB, fwdDataB); else passed++;
        wbHold = 1'b0;
        tick();
        total++; if (fwdHitA !== eh || fwdDataA !== e_b)
            $display("FAIL fwd_queue_over_outreg got %b/%h exp %b/%h", fwdHitA, fwdDataA, eh, e_b); else passed++;
        tick();
        total++; if (fwdHitA !== eh || fwdDataA !== e_b)
            $display("FAIL fwd_outreg got %b/%h exp %b/%h", fwdHitA, fwdDataA, eh, e_b); else passed++;
        tick();
        total++; if (fwdHitA !== 1'b0 || fwdDataA !== 32'h0)
            $display("FAIL fwd_idle got %b/%h exp 0/0", fwdHitA, fwdDataA); else passed++;
    endtask

    task automatic test_reset_mid();
        wbHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memValid = 1'b1; memAddr = AW'(i); memData = $urandom;
            tick();
        end
        memValid = 1'b0;
        total++; if (level !== 3'd3) $display("FAIL rmid_level got %0d exp 3", level); else passed++;
        rst = 1'b1;
        #1;
        total++; if (memReady !== 1'b0) $display("FAIL rmid_ready got %b exp 0", memReady); else passed++;
        tick();
        rst = 1'b0;
        total++; if (level !== 3'd0 || write !== 1'b0 || pending !== 1'b0)
            $display("FAIL rmid_cleared got level %0d write %b pending %b exp 0/0/0", level, write, pending); else passed++;
        wbHold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (write !== 1'b0) $display("FAIL rmid_ghost%0d got %b exp 0", i, write); else passed++;
        end
    endtask

    task automatic test_random();
        ent_t          q[$];
        ent_t          e;
        logic          ew, have_mem, have_alu, full, erm, era, eh_a, eh_b;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed, efa, efb;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ew = 1'b0; ea = '0; ed = '0;
        have_mem = 1'b0; have_alu = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!have_mem && $urandom_range(0, 2) == 0) begin
                have_mem = 1'b1; memAddr = AW'($urandom_range(0, 7)); memData = $urandom;
            end
            if (!have_alu && $urandom_range(0, 1) == 0) begin
                have_alu = 1'b1; aluAddr = AW'($urandom_range(0, 7)); aluData = $urandom;
            end
            memValid = have_mem;
            aluValid = have_alu;
            wbHold   = ((cyc % 40) < 12) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            fwdAddrA = AW'($urandom_range(0, 7));
            fwdAddrB = AW'($urandom_range(0, 7));
            #1;
            full = (q.size() == DEPTH);
            erm  = !full;
            era  = !full && !have_mem;
            total++; if (memReady !== erm) $display("FAIL rnd_memready c%0d got %b exp %b", cyc, memReady, erm); else passed++;
            total++; if (aluReady !== era) $display("FAIL rnd_aluready c%0d got %b exp %b", cyc, aluReady, era); else passed++;
            if (!wbHold && q.size() != 0) begin
                e = q.pop_front();
                ew = 1'b1; ea = e.a; ed = e.d;
            end else begin
                ew = 1'b0;
            end
            if (have_mem && erm) begin
                e.a = memAddr; e.d = memData; q.push_back(e); have_mem = 1'b0;
            end else if (have_alu && era) begin
                e.a = aluAddr; e.d = aluData; q.push_back(e); have_alu = 1'b0;
            end
            tick();
            total++; if (write !== ew) $display("FAIL rnd_write c%0d got %b exp %b", cyc, write, ew); else passed++;
            total++; if (wrAddr !== ea || wrData !== ed)
                $display("FAIL rnd_wr c%0d got %0d/%h exp %0d/%h", cyc, wrAddr, wrData, ea, ed); else passed++;
            total++; if (level !== 3'(q.size())) $display("FAIL rnd_level c%0d got %0d exp %0d", cyc, level, q.size()); else passed++;
            total++; if (pending !== (q.size() != 0 || ew))
                $display("FAIL rnd_pending c%0d got %b exp %b", cyc, pending, (q.size() != 0 || ew)); else passed++;
            eh_a = 1'b0; efa = '0; eh_b = 1'b0; efb = '0;
            if (FWD_ON) begin
                if (ew && ea == fwdAddrA) begin eh_a = 1'b1; efa = ed; end
                if (ew && ea == fwdAddrB) begin eh_b = 1'b1; efb = ed; end
                foreach (q[i]) begin
                    if (q[i].a == fwdAddrA) begin eh_a = 1'b1; efa = q[i].d; end
                    if (q[i].a == fwdAddrB) begin eh_b = 1'b1; efb = q[i].d; end
                end
            end
            total++; if (fwdHitA !== eh_a || fwdDataA !== efa)
                $display("FAIL rnd_fwdA c%0d got %b/%h exp %b/%h", cyc, fwdHitA, fwdDataA, eh_a, efa); else passed++;
            total++; if (fwdHitB !== eh_b || fwdDataB !== efb)
                $display("FAIL rnd_fwdB c%0d got %b/%h exp %b/%h", cyc, fwdHitB, fwdDataB, eh_b, efb); else passed++;
        end
        memValid = 1'b0; aluValid = 1'b0; wbHold = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        memValid = 1'b0; memAddr = '0; memData = '0;
        aluValid = 1'b0; aluAddr = '0; aluData = '0;
        wbHold = 1'b0; fwdAddrA = '0; fwdAddrB = '0;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_arbitration();
        test_hold_full();
        test_forwarding();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_write_back_unit.md
Name: reg_write_back_unit

Overview:
Write-back stage directly upstream of the register file unit's single write port. Accepts results from the memory stage and the ALU stage through valid/ready handshakes. Arbitrates between them (memory wins) and buffers accepted results in a small in-order queue. Drains one entry per cycle into the register file's write/wrAddr/wrData port, unless pipeline control holds it off.

Parameters:
WIDTH, 32, data word width; matches the register file data width.
SIZE, 8, number of registers; address width is $clog2(SIZE).
DEPTH, 4, queue entries; must be >= 2, need not be a power of two.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
memValid  in  1  memory-stage result valid.
memAddr  in  $clog2(SIZE)  memory-stage target register.
memData  in  WIDTH  memory-stage result.
memReady  out  1  memory-stage result accepted this cycle when memValid is also high.
aluValid  in  1  ALU result valid.
aluAddr  in  $clog2(SIZE)  ALU target register.
aluData  in  WIDTH  ALU result.
aluReady  out  1  ALU result accepted this cycle when aluValid is also high.
wbHold  in  1  pipeline control: suppress draining this cycle.
write  out  1  register file write enable; registered.
wrAddr  out  $clog2(SIZE)  register file write address; registered.
wrData  out  WIDTH  register file write data; registered.
level  out  $clog2(DEPTH+1)  current queue occupancy.
pending  out  1  high when level != 0 or write == 1.
fwdAddrA  in  $clog2(SIZE)  forwarding lookup address A (optional feature).
fwdAddrB  in  $clog2(SIZE)  forwarding lookup address B (optional feature).
fwdHitA  out  1  forwarding hit for address A.
fwdDataA  out  WIDTH  forwarding data for address A.
fwdHitB  out  1  forwarding hit for address B.
fwdDataB  out  WIDTH  forwarding data for address B.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: write=0, wrAddr=0, wrData=0, level=0, head/tail pointers=0, all queue entries invalid.
- Readiness during reset: memReady and aluReady are 0 while rst is high.
- memReady = !full.
- aluReady = !full && !memValid. Fixed priority: memory beats ALU.
- Neither ready depends on its own valid input, so there is no combinational valid-to-ready loop.
- Handshake: transfer occurs on a rising edge with valid && ready. A source holds valid, addr and data stable until that edge. At most one enqueue per cycle.
- pop = !wbHold && level != 0. On pop, the head is copied to wrAddr/wrData and write <= 1. Otherwise write <= 0 and wrAddr/wrData keep their values.
- Each entry produces exactly one single-cycle write pulse.
- Latency: an entry accepted at edge k, with an empty queue and wbHold low, drives write=1 in the cycle after edge k+1. The register file captures it at edge k+2.
- Ordering: writes leave in acceptance order. Multiple writes to the same register are all issued; the last one wins in the register file.
- Simultaneous enqueue and pop: both take effect; level is unchanged.
- Full: level == DEPTH. Both readies are 0. An enqueue into the slot freed by a same-cycle pop is not allowed.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0.
- wbHold high: no pop, write=0 next cycle, queue contents frozen apart from enqueues.
- Reset mid-operation: all buffered entries are discarded. write=0 from the next cycle; no pulses for discarded entries.

Optional Feature:
Macro: VCPU32_WB_FWD_EN.
- Defined: fwdHitX/fwdDataX are combinational lookups of fwdAddrX over the valid queue entries plus the output register (when write=1).
  - Priority: youngest queue entry (tail-1 back to head), then the output register.
  - Miss: hit=0, data=0.
- Undefined: fwd outputs are tied to 0, fwdAddr inputs are ignored, and no comparators are built.

Decomposition:
- Shared package vcpu32_pkg:
  - WORD_WIDTH = 32
  - REG_COUNT = 8
  - REG_ADDR_WIDTH = $clog2(REG_COUNT)
  - typedef wb_entry_t {addr, data}
- Sub-module wb_fifo: a generic synchronous FIFO of wb_entry_t with push/pop/full/level, exposing all entries plus valid bits for the forwarding lookup. Arbitration, output register and forwarding stay in the top module.

Test Plan:
1. Reset: hold rst=1 for 2 edges, then rst=0 -> write=0, wrAddr=0, wrData=0, level=0, memReady=aluReady=1, pending=0.
2. Single ALU result: aluValid=1, aluAddr=3, aluData=0xDEADBEEF for one accepted cycle -> write=1 for exactly one cycle, 2 edges after acceptance, with wrAddr=3, wrData=0xDEADBEEF.
3. Arbitration: memValid (addr 5, data 0x11111111) and aluValid (addr 6, data 0x22222222) together -> aluReady=0 in the first cycle, memory accepted first. Register file writes follow on consecutive cycles: 5/0x11111111, then 6/0x22222222.
4. Hold and full: wbHold=1, enqueue 4 ALU results (DEPTH=4) -> level=4, memReady=aluReady=0, fifth result waits. Drop wbHold -> 4 in-order write pulses, then the fifth is accepted and written.
5. Forwarding (macro on): wbHold=1, enqueue r2=0x0000000A then r2=0x0000000B.
   - fwdAddrA=2 -> fwdHitA=1, fwdDataA=0x0000000B.
   - fwdAddrB=7 -> fwdHitB=0, fwdDataB=0.
   - Macro off -> all fwd outputs 0.
6. Reset mid-operation: level=3 under wbHold, assert rst for one edge -> level=0, write=0 in the following cycle, no write pulses after wbHold is dropped.
